// File: rtl/sysid_check_ctrl.sv
// System ID / timestamp check controller: reads two words over Avalon-MM and compares them.
// Optional macro SYSID_CHECK_AUTOSTART_EN issues one internal start shortly after reset release.
module sysid_check_ctrl #(
   parameter logic [31:0] EXP_ID         = 32'h0000_0000,
   parameter logic [31:0] EXP_TS         = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRY      = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_err,
   output logic        ts_err,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      CMP,
      FIN
   } state_t;

   localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

   state_t      state, state_n;
   logic        rd_n, addr_n;
   logic [15:0] stall_cnt, stall_n;
   logic [3:0]  retry_cnt, retry_n;
   logic [31:0] id_n, ts_n;
   logic        ide_n, tse_n, toe_n, pass_n;
   logic        go;

`ifdef SYSID_CHECK_AUTOSTART_EN
   logic [1:0] boot_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         boot_cnt <= 2'd0;
      else if (boot_cnt != 2'd3)
         boot_cnt <= boot_cnt + 2'd1;
   end

   assign go = start | (boot_cnt == 2'd1);
`else
   assign go = start;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         stall_cnt   <= '0;
         retry_cnt   <= '0;
         id_value    <= '0;
         ts_value    <= '0;
         id_err      <= 1'b0;
         ts_err      <= 1'b0;
         timeout_err <= 1'b0;
         pass        <= 1'b0;
      end else begin
         state       <= state_n;
         avm_read    <= rd_n;
         avm_address <= addr_n;
         stall_cnt   <= stall_n;
         retry_cnt   <= retry_n;
         id_value    <= id_n;
         ts_value    <= ts_n;
         id_err      <= ide_n;
         ts_err      <= tse_n;
         timeout_err <= toe_n;
         pass        <= pass_n;
      end
   end

   always_comb begin
      state_n = state;
      rd_n    = avm_read;
      addr_n  = avm_address;
      stall_n = stall_cnt;
      retry_n = retry_cnt;
      id_n    = id_value;
      ts_n    = ts_value;
      ide_n   = id_err;
      tse_n   = ts_err;
      toe_n   = timeout_err;
      pass_n  = pass;
      unique case (state)
         IDLE: begin
            if (go) begin
               state_n = RD_ID;
               rd_n    = 1'b1;
               addr_n  = 1'b0;
               stall_n = '0;
               retry_n = '0;
               ide_n   = 1'b0;
               tse_n   = 1'b0;
               toe_n   = 1'b0;
               pass_n  = 1'b0;
            end
         end
         RD_ID, RD_TS: begin
            if (!avm_read) begin
               // one idle cycle after a timeout, then re-issue
               rd_n    = 1'b1;
               stall_n = '0;
            end else if (!avm_waitrequest) begin
               stall_n = '0;
               retry_n = '0;
               if (state == RD_ID) begin
                  id_n    = avm_readdata;
                  state_n = RD_TS;
                  addr_n  = 1'b1;
               end else begin
                  ts_n    = avm_readdata;
                  state_n = CMP;
                  rd_n    = 1'b0;
                  addr_n  = 1'b0;
               end
            end else if (stall_cnt == STALL_LAST) begin
               rd_n    = 1'b0;
               stall_n = '0;
               if (retry_cnt == RETRY_MAX) begin
                  toe_n   = 1'b1;
                  state_n = FIN;
                  addr_n  = 1'b0;
               end else begin
                  retry_n = retry_cnt + 4'd1;
               end
            end else begin
               stall_n = stall_cnt + 16'd1;
            end
         end
         CMP: begin
            ide_n   = (id_value != EXP_ID);
            tse_n   = (ts_value != EXP_TS);
            pass_n  = (id_value == EXP_ID) && (ts_value == EXP_TS) && !timeout_err;
            state_n = FIN;
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state == RD_ID) || (state == RD_TS) || (state == CMP);
   assign done = (state == FIN);

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameter EXP_ID, default 32'h0000_0000, expected system ID word (address 0).
REQ-002 Parameter EXP_TS, default 32'h0000_0000, expected timestamp word (address 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max waitrequest-stalled cycles per read attempt (1..65535).
REQ-004 Parameter MAX_RETRY, default 2, re-issues allowed per word after a timeout (0..15).
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to run a check sequence.
REQ-008 avm_address  out  1  Avalon-MM master word address to the ID slave.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_readdata  in  32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 avm_waitrequest  in  1  slave stall.
REQ-012 busy  out  1  sequence in progress.
REQ-013 done  out  1  one-cycle pulse at sequence end.
REQ-014 pass  out  1  last result: both words matched, no timeout.
REQ-015 id_err / ts_err / timeout_err  out  1 each  sticky result flags of last sequence.
REQ-016 id_value / ts_value  out  32 each  last captured words.

Function
REQ-017 FSM states SHALL be IDLE, RD_ID, RD_TS, CMP, FIN; IDLE entered on reset.
REQ-018 start=1 in IDLE SHALL move to RD_ID next cycle, clear pass and all error flags, set busy; start while busy SHALL be ignored.
REQ-019 RD_ID: avm_address=0, avm_read=1 held until waitrequest=0; that cycle captures avm_readdata into id_value and moves to RD_TS.
REQ-020 RD_TS: same with avm_address=1, capture into ts_value, then CMP.
REQ-021 avm_address and avm_read SHALL be registered and stable while waitrequest=1.
REQ-022 CMP (one cycle): id_err = (id_value!=EXP_ID), ts_err = (ts_value!=EXP_TS); then FIN.
REQ-023 FIN (one cycle): done=1, pass = !id_err && !ts_err && !timeout_err, busy deasserted, return to IDLE.
REQ-024 Zero-wait latency: start sampled at cycle 0 -> avm_read addr 0 at cycle 1, addr 1 at cycle 2, CMP cycle 3, done pulse cycle 4.
REQ-025 Stall counter SHALL count cycles with avm_read=1 and waitrequest=1, cleared on each new attempt; at TIMEOUT_CYCLES avm_read SHALL drop for exactly one cycle and the same word be re-issued.
REQ-026 Retry counter per word cleared on entering RD_ID/RD_TS; a timeout with retries already equal to MAX_RETRY SHALL set timeout_err and go directly to FIN (captured word of that state unchanged, id_err/ts_err not evaluated, stay 0).
REQ-027 waitrequest=0 in the same cycle the stall counter reaches TIMEOUT_CYCLES SHALL count as a successful read (no timeout).
REQ-028 pass, flags, id_value, ts_value SHALL hold until the next accepted start.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, all flags 0, id_value=ts_value=0, counters 0, including mid-read.
REQ-030 After reset release no Avalon read SHALL occur without start (unless REQ-031 applies).

Configuration
REQ-031 Macro SYSID_CHECK_AUTOSTART_EN: when defined, one internal start SHALL be generated in the second cycle after reset_n deasserts (external start still honoured afterwards); when undefined, sequences run only on start.

Verification
REQ-032 EXP_ID=32'h4055_D34A, EXP_TS=32'h4E0B_311E, slave returns both, no waitrequest, start at cycle 0 -> done at cycle 4, pass=1, flags 0.
REQ-033 Slave returns ID 32'h0000_0001 -> id_err=1, ts_err=0, pass=0, id_value=32'h0000_0001.
REQ-034 TIMEOUT_CYCLES=4, MAX_RETRY=1, waitrequest stuck 1 on addr 1 -> two attempts of 4 stalled cycles each separated by one idle cycle, then timeout_err=1, pass=0, done pulse.
REQ-035 waitrequest=1 for 3 cycles on each word, TIMEOUT_CYCLES=255 -> avm_address/avm_read stable during stall, pass=1, done at cycle 10.
REQ-036 reset_n pulsed low during RD_TS stall -> avm_read=0 same cycle, all outputs 0; with SYSID_CHECK_AUTOSTART_EN defined, a new sequence begins 2 cycles after release.
